// File: rtl/instr_fetch_if.sv
// instr_fetch_if
//   Bundles the instruction-memory request/response and the execute-side
//   valid/ready handshake of the fetch stage.
//   master : the fetch stage (drives memory requests and instructions)
//   slave  : the environment (memory + execute + branch unit)
//
//   imem_rd_en / imem_addr   read request and word address
//   imem_data                read data, valid the cycle after a request
//   instr / instr_pc         instruction at FIFO head and its address
//   instr_valid/instr_ready  delivery handshake to execute
//   redirect / redirect_pc   flush and restart fetch at a new address
//   halted                   halt opcode consumed, fetch stopped
interface instr_fetch_if #(
  parameter int PC_WIDTH = 5
);
  logic                imem_rd_en;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_data;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                instr_valid;
  logic                instr_ready;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                halted;

  modport master (
    output imem_rd_en, imem_addr, instr, instr_pc, instr_valid, halted,
    input  imem_data, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_rd_en, imem_addr, instr, instr_pc, instr_valid, halted,
    output imem_data, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
//   Fetch stage between a synchronous instruction memory (one-cycle read
//   latency) and the execute datapath. Issues word addresses, pushes each
//   returned word with its address into a small prefetch FIFO and offers
//   the FIFO head to execute over valid/ready. Supports redirect (flush and
//   restart) and stops fetching once the halt opcode 7'b1111111 is fetched.
//
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  instr_fetch_if.master: memory request/response, instruction
//        delivery handshake, redirect and halted status
module instr_fetch #(
  parameter int PC_WIDTH = 5,
  parameter int DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [6:0]      HALT_OP = 7'b1111111;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic                stop_q, stop_d;
  logic                halted_q, halted_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;

  logic [31:0]         fifo_instr_q [DEPTH];
  logic [PC_WIDTH-1:0] fifo_pc_q    [DEPTH];

  logic                head_valid;
  logic                deq;
  logic                push;
  logic                issue;
  logic [CW:0]         occupancy;
  logic [31:0]         head_instr;
  logic [PC_WIDTH-1:0] head_pc;

  assign head_instr = fifo_instr_q[rd_ptr_q];
  assign head_pc    = fifo_pc_q[rd_ptr_q];

  // Once halted the remaining FIFO contents are hidden from execute.
  assign head_valid = (count_q != '0) && !halted_q;
  assign deq        = head_valid && bus.instr_ready;
  // A response landing in a redirect cycle belongs to the old stream.
  assign push       = inflight_q && !bus.redirect;

  // Space check counts the word that will be popped this cycle and the one
  // still on its way back from memory, so a push always finds a free slot.
  assign occupancy  = {1'b0, count_q} - (CW+1)'(deq) + (CW+1)'(inflight_q);
  assign issue      = !rst && !stop_q && !halted_q && !bus.redirect &&
                      (occupancy < DEPTH_C);

  assign bus.imem_rd_en  = issue;
  assign bus.imem_addr   = fetch_pc_q;
  // Storage is not reset, so gate the head to zero while nothing is valid.
  assign bus.instr       = head_valid ? head_instr : '0;
  assign bus.instr_pc    = head_valid ? head_pc : '0;
  assign bus.instr_valid = head_valid;
  assign bus.halted      = halted_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    stop_d        = stop_q;
    halted_d      = halted_q;
    count_d       = count_q + CW'(push) - CW'(deq);
    rd_ptr_d      = rd_ptr_q + AW'(deq);
    wr_ptr_d      = wr_ptr_q + AW'(push);

    if (issue) begin
      fetch_pc_d    = fetch_pc_q + 1'b1;
      inflight_pc_d = fetch_pc_q;
    end
    if (push && (bus.imem_data[6:0] == HALT_OP)) begin
      stop_d = 1'b1;
    end
    if (deq && (head_instr[6:0] == HALT_OP)) begin
      halted_d = 1'b1;
    end

    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      inflight_d = 1'b0;
      stop_d     = 1'b0;
      halted_d   = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      stop_q        <= 1'b0;
      halted_q      <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      stop_q        <= stop_d;
      halted_q      <= halted_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // FIFO storage: data only, validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= bus.imem_data;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
//   Drives instr_fetch with directed phases (stream, backpressure, redirect,
//   halt, reset mid-stream) and a randomized phase, comparing every cycle
//   against a queue-based reference model of the fetch stage.
module tb_instr_fetch;
  localparam int PC_WIDTH = 5;
  localparam int DEPTH    = 4;
  localparam int NPC      = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  instr_fetch #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] instr;
    int          pc;
  } entry_t;

  logic [31:0]         mem [NPC];
  entry_t              q[$];
  int                  m_fetch_pc;
  int                  m_inflight_pc;
  bit                  m_inflight;
  bit                  m_stop;
  bit                  m_halted;
  bit                  mem_pend;
  logic [PC_WIDTH-1:0] mem_addr;
  int                  checks   = 0;
  int                  failures = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_halt(input logic [31:0] w);
    return w[6:0] == 7'h7F;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.imem_data   = mem_pend ? mem[mem_addr] : $urandom;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    #1;
    check_val("rst_rd_en",    bus.imem_rd_en,  0);
    check_val("rst_addr",     bus.imem_addr,   0);
    check_val("rst_instr",    bus.instr,       0);
    check_val("rst_instr_pc", bus.instr_pc,    0);
    check_val("rst_valid",    bus.instr_valid, 0);
    check_val("rst_halted",   bus.halted,      0);
    mem_pend      = 1'b0;
    q.delete();
    m_fetch_pc    = 0;
    m_inflight_pc = 0;
    m_inflight    = 0;
    m_stop        = 0;
    m_halted      = 0;
  endtask

  task automatic step(input bit rdy, input bit redir, input int rpc);
    bit exp_valid;
    bit deq;
    bit issue;
    int occ;
    @(negedge clk);
    rst = 1'b0;
    bus.instr_ready = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = PC_WIDTH'(rpc);
    bus.imem_data   = mem_pend ? mem[mem_addr] : $urandom;
    #1;
    exp_valid = (q.size() > 0) && !m_halted;
    deq       = exp_valid && rdy;
    occ       = q.size() - int'(deq) + int'(m_inflight);
    issue     = !m_stop && !m_halted && !redir && (occ < DEPTH);
    check_val("instr_valid", bus.instr_valid, exp_valid);
    if (exp_valid) begin
      check_val("instr",    bus.instr,    q[0].instr);
      check_val("instr_pc", bus.instr_pc, q[0].pc);
    end
    check_val("imem_rd_en", bus.imem_rd_en, issue);
    if (issue) check_val("imem_addr", bus.imem_addr, m_fetch_pc);
    check_val("halted", bus.halted, m_halted);

    mem_pend = bus.imem_rd_en;
    mem_addr = bus.imem_addr;

    if (redir) begin
      q.delete();
      m_inflight = 0;
      m_stop     = 0;
      m_halted   = 0;
      m_fetch_pc = rpc % NPC;
    end else begin
      if (deq) begin
        if (is_halt(q[0].instr)) m_halted = 1;
        void'(q.pop_front());
      end
      if (m_inflight) begin
        q.push_back('{mem[m_inflight_pc], m_inflight_pc});
        if (is_halt(mem[m_inflight_pc])) m_stop = 1;
      end
      if (issue) begin
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc    = (m_fetch_pc + 1) % NPC;
        m_inflight    = 1;
      end else begin
        m_inflight = 0;
      end
    end
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_data   = '0;
    mem_pend        = 1'b0;
    mem_addr        = '0;
    for (int k = 0; k < NPC; k++) mem[k] = 32'h1000_0000 + k;

    // Stream, wrap and backpressure
    do_reset();
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 0);

    // Redirect with two buffered entries and a fetch in flight
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 20);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0);

    // Reset mid-stream with count = 3 and a fetch in flight
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0);

    // Halt at word 5, then redirect to 0 resumes fetch
    mem[5] = 32'h0000_007F;
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0);

    // Randomized traffic with occasional halt words
    for (int k = 0; k < NPC; k++) begin
      mem[k] = $urandom;
      if ($urandom_range(7) == 0) mem[k][6:0] = 7'h7F;
      else if (mem[k][6:0] == 7'h7F) mem[k][0] = 1'b0;
    end
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 199) begin
        do_reset();
      end else begin
        step($urandom_range(9) < 7, $urandom_range(24) == 0, int'($urandom_range(NPC-1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
